// File: rtl/erosion_packer.sv
// Packs the eroded pixel stream four-at-a-time into 32-bit AXI-Stream words,
// tagging frame start/end, buffered by a small first-word fall-through FIFO.
module erosion_packer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  input  logic        sensor_state,
  input  logic        erosion_valid,
  input  logic [7:0]  erosion_dout,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [23:0]   partial;
  logic          sof_pend;

  logic [33:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          accept;
  logic [1:0]    lane;
  logic          wr_req;
  logic          wr_en;
  logic          rd_en;
  logic          full;
  logic          word_last;
  logic [33:0]   new_entry;

  always_comb begin
    accept    = erosion_valid & sensor_state;
    lane      = col[1:0];
    wr_req    = accept && (lane == 2'd3);
    full      = (count == FULL_CNT);
    rd_en     = m_axis_tvalid & m_axis_tready;
    wr_en     = wr_req && (!full || rd_en);
    word_last = (row == ROW_LAST) && (col == COL_LAST);
    new_entry = {word_last, sof_pend, erosion_dout, partial};
  end

  // Raster position and partial word; dropping sensor_state abandons the group.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset || !sensor_state) begin
      col      <= '0;
      row      <= '0;
      partial  <= '0;
      sof_pend <= 1'b0;
    end else if (accept) begin
      case (lane)
        2'd0: begin
          partial[7:0] <= erosion_dout;
          sof_pend     <= (row == '0) && (col == '0);
        end
        2'd1: partial[15:8]  <= erosion_dout;
        2'd2: partial[23:16] <= erosion_dout;
        default: partial     <= '0;
      endcase
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + 1'b1;
        if (word_last) frame_count <= frame_count + 16'd1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      // A completed word that finds no room and no concurrent read is lost.
      if (wr_req && full && !rd_en) overflow <= 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    m_axis_tvalid = (count != '0);
    m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr][31:0] : 32'd0;
    m_axis_tuser  = m_axis_tvalid & mem[rd_ptr][32];
    m_axis_tlast  = m_axis_tvalid & mem[rd_ptr][33];
  end

endmodule

// File: tb/tb_erosion_packer.sv
// Directed bench for erosion_packer on an 8x2 frame with a 4-entry FIFO:
// a per-cycle vector table plus hand-written overflow, full-FIFO and reset sequences.
module tb_erosion_packer;

  localparam int W = 8;
  localparam int H = 2;
  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        sensor_state;
  logic        erosion_valid;
  logic [7:0]  erosion_dout;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        overflow;
  logic [15:0] frame_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  erosion_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .s_axi_aclk   (clock),
    .s_axi_areset (reset),
    .sensor_state (sensor_state),
    .erosion_valid(erosion_valid),
    .erosion_dout (erosion_dout),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        r;
    logic        tv;
    logic [31:0] data;
    logic        tu;
    logic        tl;
    logic [15:0] fc;
    logic        ov;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic v, input logic s, input logic [7:0] d,
                              input logic r, input logic tv, input logic [31:0] data,
                              input logic tu, input logic tl, input logic [15:0] fc);
    vec_t x;
    x.v = v; x.s = s; x.d = d; x.r = r;
    x.tv = tv; x.data = data; x.tu = tu; x.tl = tl; x.fc = fc; x.ov = 1'b0;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d, input logic r);
    erosion_valid = v;
    sensor_state  = s;
    erosion_dout  = d;
    m_axis_tready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] packWord(input int first);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(first + k);
    return w;
  endfunction

  // Drains with tready=1, expecting exactly n words whose pixels count up from base.
  task automatic drain(input string tag, input int base, input int n, input int user_idx, input int last_idx);
    int got = 0;
    erosion_valid = 1'b0;
    sensor_state  = 1'b1;
    m_axis_tready = 1'b1;
    for (int c = 0; c < n + 4; c++) begin
      if (m_axis_tvalid) begin
        if (got < n) begin
          checkOutput($sformatf("%s_w%0d_data", tag, got), m_axis_tdata, packWord(base + 4 * got));
          checkOutput($sformatf("%s_w%0d_tuser", tag, got), 32'(m_axis_tuser), 32'(got == user_idx));
          checkOutput($sformatf("%s_w%0d_tlast", tag, got), 32'(m_axis_tlast), 32'(got == last_idx));
        end
        got++;
      end
      @(posedge clock);
      #1;
    end
    checkOutput($sformatf("%s_word_count", tag), 32'(got), 32'(n));
  endtask

  initial begin
    reset         = 1'b1;
    sensor_state  = 1'b0;
    erosion_valid = 1'b0;
    erosion_dout  = 8'h00;
    m_axis_tready = 1'b0;

    // One full 8x2 frame, abort mid-group, then backpressure stability.
    vecs[0]  = mk(1, 1, 8'h01, 1, 0, 32'h0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 8'h02, 1, 0, 32'h0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 8'h03, 1, 0, 32'h0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 8'h04, 1, 1, 32'h04030201, 1, 0, 0);
    vecs[4]  = mk(0, 1, 8'h00, 1, 0, 32'h0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 8'h05, 1, 0, 32'h0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 8'h06, 1, 0, 32'h0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 8'h07, 1, 0, 32'h0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 8'h08, 1, 1, 32'h08070605, 0, 0, 0);
    vecs[9]  = mk(1, 1, 8'h11, 1, 0, 32'h0, 0, 0, 0);
    vecs[10] = mk(1, 1, 8'h12, 1, 0, 32'h0, 0, 0, 0);
    vecs[11] = mk(1, 1, 8'h13, 1, 0, 32'h0, 0, 0, 0);
    vecs[12] = mk(1, 1, 8'h14, 1, 1, 32'h14131211, 0, 0, 0);
    vecs[13] = mk(1, 1, 8'h15, 1, 0, 32'h0, 0, 0, 0);
    vecs[14] = mk(1, 1, 8'h16, 1, 0, 32'h0, 0, 0, 0);
    vecs[15] = mk(1, 1, 8'h17, 1, 0, 32'h0, 0, 0, 0);
    vecs[16] = mk(1, 1, 8'h18, 1, 1, 32'h18171615, 0, 1, 1);
    vecs[17] = mk(0, 1, 8'h00, 1, 0, 32'h0, 0, 0, 1);
    vecs[18] = mk(1, 1, 8'h55, 1, 0, 32'h0, 0, 0, 1);
    vecs[19] = mk(1, 1, 8'h66, 1, 0, 32'h0, 0, 0, 1);
    vecs[20] = mk(1, 0, 8'h77, 1, 0, 32'h0, 0, 0, 1);
    vecs[21] = mk(1, 1, 8'hA0, 1, 0, 32'h0, 0, 0, 1);
    vecs[22] = mk(1, 1, 8'hA1, 1, 0, 32'h0, 0, 0, 1);
    vecs[23] = mk(1, 1, 8'hA2, 1, 0, 32'h0, 0, 0, 1);
    vecs[24] = mk(1, 1, 8'hA3, 1, 1, 32'hA3A2A1A0, 1, 0, 1);
    vecs[25] = mk(0, 1, 8'h00, 1, 0, 32'h0, 0, 0, 1);
    vecs[26] = mk(1, 1, 8'hB0, 0, 0, 32'h0, 0, 0, 1);
    vecs[27] = mk(1, 1, 8'hB1, 0, 0, 32'h0, 0, 0, 1);
    vecs[28] = mk(1, 1, 8'hB2, 0, 0, 32'h0, 0, 0, 1);
    vecs[29] = mk(1, 1, 8'hB3, 0, 1, 32'hB3B2B1B0, 0, 0, 1);
    vecs[30] = mk(0, 1, 8'h00, 0, 1, 32'hB3B2B1B0, 0, 0, 1);
    vecs[31] = mk(0, 1, 8'h00, 1, 0, 32'h0, 0, 0, 1);

    doReset();
    checkOutput("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("reset_tdata", m_axis_tdata, 32'd0);
    checkOutput("reset_tuser", 32'(m_axis_tuser), 32'd0);
    checkOutput("reset_tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_frame_count", 32'(frame_count), 32'd0);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r);
      checkOutput($sformatf("vec%0d_tvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].tv));
      checkOutput($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].data);
      checkOutput($sformatf("vec%0d_tuser", i), 32'(m_axis_tuser), 32'(vecs[i].tu));
      checkOutput($sformatf("vec%0d_tlast", i), 32'(m_axis_tlast), 32'(vecs[i].tl));
      checkOutput($sformatf("vec%0d_frame_count", i), 32'(frame_count), 32'(vecs[i].fc));
      checkOutput($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
    end

    // Overflow: 5 words with no reads; the fifth is dropped.
    doReset();
    for (int p = 0; p < 4 * (D + 1); p++) applyStimulus(1'b1, 1'b1, 8'(p), 1'b0);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_frame_count", 32'(frame_count), 32'd1);
    checkOutput("ovf_head", m_axis_tdata, packWord(0));
    drain("ovf", 0, D, 0, 3);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a write and a read on the same edge.
    doReset();
    for (int p = 0; p < 4 * D; p++) applyStimulus(1'b1, 1'b1, 8'(p), 1'b0);
    for (int p = 4 * D; p < 4 * D + 3; p++) applyStimulus(1'b1, 1'b1, 8'(p), 1'b0);
    applyStimulus(1'b1, 1'b1, 8'(4 * D + 3), 1'b1);
    checkOutput("fullrw_overflow", 32'(overflow), 32'd0);
    checkOutput("fullrw_frame_count", 32'(frame_count), 32'd1);
    drain("fullrw", 4, D, 3, 2);

    // Reset mid-frame with words queued and overflow set.
    doReset();
    for (int p = 0; p < 4 * (D + 1); p++) applyStimulus(1'b1, 1'b1, 8'(p), 1'b0);
    drain("prerst", 0, D, 0, 3);
    for (int p = 0; p < 14; p++) applyStimulus(1'b1, 1'b1, 8'(8'h40 + p), 1'b0);
    checkOutput("prerst_overflow", 32'(overflow), 32'd1);
    checkOutput("prerst_tvalid", 32'(m_axis_tvalid), 32'd1);
    checkOutput("prerst_frame_count", 32'(frame_count), 32'd2);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    reset = 1'b0;
    checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_tdata", m_axis_tdata, 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    applyStimulus(1'b1, 1'b1, 8'hC0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hC1, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hC2, 1'b1);
    checkOutput("postrst_no_early_word", 32'(m_axis_tvalid), 32'd0);
    applyStimulus(1'b1, 1'b1, 8'hC3, 1'b1);
    checkOutput("postrst_tvalid", 32'(m_axis_tvalid), 32'd1);
    checkOutput("postrst_tdata", m_axis_tdata, 32'hC3C2C1C0);
    checkOutput("postrst_tuser", 32'(m_axis_tuser), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/erosion_packer.md
EROSION_PACKER -- requirements
Module: erosion_packer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, meaning pixels per row; a multiple of 4, at most 1024.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, meaning rows per frame, at most 1024.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning output word FIFO entries; a power of 2, at least 4.
REQ-004 s_axi_aclk  input  1  sole clock; all logic rising-edge.
REQ-005 s_axi_areset  input  1  reset; synchronous, active-high.
REQ-006 sensor_state  input  1  1 = frame capture active; 0 = idle/abort.
REQ-007 erosion_valid  input  1  pixel strobe from the erosion stage; no backpressure possible.
REQ-008 erosion_dout  input  8  eroded pixel, raster order.
REQ-009 m_axis_tdata  output  32  four packed pixels.
REQ-010 m_axis_tvalid  output  1  word available.
REQ-011 m_axis_tready  input  1  downstream accept.
REQ-012 m_axis_tuser  output  1  start of frame, on the first word of a frame.
REQ-013 m_axis_tlast  output  1  end of frame, on the last word of a frame.
REQ-014 overflow  output  1  sticky flag: a word was dropped.
REQ-015 frame_count  output  16  frames fully packed.

Function
REQ-016 Pixel acceptance SHALL occur only on cycles with erosion_valid=1 and sensor_state=1; other cycles SHALL leave packer state unchanged, apart from the abort behaviour in REQ-023.
REQ-017 Packing SHALL be little-endian: pixel k of a group goes to tdata[8k+7:8k], k=0..3, and the first pixel of a row is k=0.
REQ-018 Column counter col SHALL run 0..IMG_WIDTH-1 and increment per accepted pixel; at IMG_WIDTH-1 it SHALL wrap to 0 and increment row.
REQ-019 Row counter row SHALL run 0..IMG_HEIGHT-1; on the wrap from the last pixel of row IMG_HEIGHT-1 it SHALL return to 0.
REQ-020 On acceptance of pixel k=3 in cycle N, the assembled word SHALL be written to the FIFO at the end of cycle N.
  - tuser=1 when the word holds pixel (row 0, col 0).
  - tlast=1 when the word holds pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-021 With the FIFO empty, m_axis_tvalid SHALL assert in cycle N+1 (first-word fall-through); tdata/tuser/tlast SHALL be stable while tvalid=1 and tready=0.
REQ-022 A FIFO read SHALL occur on any cycle with tvalid=1 and tready=1; words SHALL leave in write order.
REQ-023 sensor_state=0 SHALL clear col, row and the partial word within one cycle, and SHALL discard 1-3 unpacked pixels. FIFO contents SHALL remain and drain normally.
REQ-024 FIFO full with write and no read in the same cycle: the new word SHALL be dropped and overflow set to 1; overflow SHALL stay 1 until reset.
REQ-025 FIFO full with simultaneous write and read: the write SHALL be accepted and no overflow flagged.
REQ-026 FIFO empty with simultaneous write: the read SHALL NOT occur (tvalid=0); the word SHALL appear the next cycle.
REQ-027 frame_count SHALL increment by 1 when a tlast word is written into the FIFO, wrap at 16'hFFFF to 0, and not increment for dropped words.
REQ-028 Counters and FIFO pointers SHALL use full-width wrap arithmetic; occupancy SHALL be held in log2(FIFO_DEPTH)+1 bits.

Reset
REQ-029 While s_axi_areset=1 at a clock edge, every register SHALL clear on that edge:
  - col=0, row=0, partial word=0;
  - FIFO empty, so m_axis_tvalid=0, m_axis_tdata=0, tuser=0, tlast=0;
  - overflow=0, frame_count=0.
REQ-030 Reset mid-frame or mid-transfer SHALL discard all pending data; the first accepted pixel after reset is treated as (row 0, col 0).

Verification
REQ-031 Pixels 0x01,0x02,0x03,0x04 accepted on consecutive cycles, tready=1 -> one word 0x04030201 with tuser=1, tlast=0; tvalid high exactly 1 cycle, one cycle after the 4th pixel.
REQ-032 Full frame with IMG_WIDTH=8, IMG_HEIGHT=2 (16 pixels) -> 4 words; tuser on word 0, tlast on word 3; frame_count 0->1.
REQ-033 tready=0 held and 4*(FIFO_DEPTH+1) pixels sent -> FIFO full after FIFO_DEPTH words, word FIFO_DEPTH+1 dropped, overflow=1. Then tready=1 -> exactly FIFO_DEPTH words out, in order.
REQ-034 FIFO full, tready=1 in the same cycle a word completes -> no overflow; occupancy stays FIFO_DEPTH.
REQ-035 Two pixels accepted, sensor_state=0 for 1 cycle, then 4 pixels 0xA0..0xA3 -> single word 0xA3A2A1A0 with tuser=1; the first two pixels never appear.
REQ-036 s_axi_areset pulsed mid-frame with 3 words queued and overflow=1 -> next cycle tvalid=0, overflow=0, frame_count=0; the next 4 pixels produce a tuser word.
